// File: rtl/filter_pkg.sv
// ============================================================================
//  Module   : filter_pkg
//  Purpose  : Shared width defaults and sign-extension helper for the
//             filter datapath accumulator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package filter_pkg;

    localparam int c_data_w = 16;
    localparam int c_acc_w  = 20;

    // Sign-extends a default-width sample to the default accumulator width.
    function automatic logic [c_acc_w-1:0] sext(input logic [c_data_w-1:0] d);
        return {{(c_acc_w-c_data_w){d[c_data_w-1]}}, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/filter_acc_datapath.sv
// ============================================================================
//  Module   : filter_acc_datapath
//  Purpose  : Combinational sign-extend and add/select feeding the
//             accumulator register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_acc_datapath
    import filter_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ACC_W  = c_acc_w
) (
    input  logic [ACC_W-1:0]  q,
    input  logic [DATA_W-1:0] d,
    input  logic              load,
    output logic [ACC_W-1:0]  nxt
);

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;

    // Package helper only matches the default widths; other widths extend inline.
    if (DATA_W == c_data_w && ACC_W == c_acc_w) begin : g_pkg_sext
        assign w_ext = sext(d);
    end else begin : g_generic_sext
        assign w_ext = {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
    end

    assign w_sum = q + w_ext;
    assign nxt   = load ? w_ext : w_sum;

endmodule

`default_nettype wire

// File: rtl/filter_accum.sv
// ============================================================================
//  Module   : filter_accum
//  Purpose  : Signed running-sum accumulator; loads or adds a sign-extended
//             sample each enabled cycle, wrapping modulo 2^ACC_W.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_accum
    import filter_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int ACC_W  = c_acc_w
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              enable,
    input  logic              load,
    input  logic [DATA_W-1:0] D,
    output logic [ACC_W-1:0]  Q
);

    if (ACC_W <= DATA_W) begin : g_width_check
        $error("filter_accum: ACC_W must be greater than DATA_W");
    end

    logic [ACC_W-1:0] r_q;
    logic [ACC_W-1:0] w_nxt;

    filter_acc_datapath #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_datapath (
        .q    (r_q),
        .d    (D),
        .load (load),
        .nxt  (w_nxt)
    );

    // Reset outranks enable so an X on D during reset never reaches the register.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_q <= '0;
        end else if (enable) begin
            r_q <= w_nxt;
        end
    end

    assign Q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_filter_accum.sv
// Self-checking bench for filter_accum: directed plan plus randomized traffic
// compared against an integer running-sum model.
`default_nettype none

module tb_filter_accum;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] D = 16'h0000;
    logic [19:0] Q;

    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] model_q = 20'h0;

    filter_accum #(
        .DATA_W (16),
        .ACC_W  (20)
    ) dut (
        .clk    (clk),
        .rstb   (rstb),
        .enable (enable),
        .load   (load),
        .D      (D),
        .Q      (Q)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Applies one cycle of inputs, advances the model, and checks Q after the edge.
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] dd, input string tag);
        int sum;
        rstb   = r;
        enable = e;
        load   = l;
        D      = dd;
        @(posedge clk);
        if (!r) begin
            model_q = 20'h0;
        end else if (e) begin
            if (l) sum = int'($signed(dd));
            else   sum = int'(model_q) + int'($signed(dd));
            model_q = sum[19:0];
        end
        #1;
        check_val(tag, Q, model_q);
    endtask

    initial begin
        logic [19:0] held;

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'($urandom), "reset");
        check_val("reset_lit", Q, 20'h00000);

        step(1'b1, 1'b1, 1'b1, 16'h000A, "load_a");
        check_val("load_a_lit", Q, 20'h0000A);
        step(1'b1, 1'b1, 1'b0, 16'hFFFF, "add_m1");
        check_val("add_m1_lit", Q, 20'h00009);
        step(1'b1, 1'b1, 1'b0, 16'h0334, "add_334");
        check_val("add_334_lit", Q, 20'h0033D);
        step(1'b1, 1'b1, 1'b0, 16'hFFFF, "add_m1b");
        check_val("add_m1b_lit", Q, 20'h0033C);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'hAA44, "neg_acc");
            if (i == 0) check_val("neg_first_lit", Q, 20'hFAD80);
        end
        check_val("neg_tenth_lit", Q, 20'hCA9E4);

        held = Q;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'($urandom), 16'($urandom), "hold");
            check_val("hold_lit", Q, 20'hCA9E4);
        end

        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 16'h0000, "reload");
        check_val("reload_lit", Q, 20'h00000);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 16'h0001, "count");
        check_val("count_lit", Q, 20'h0000A);

        step(1'b1, 1'b1, 1'b1, 16'h7FFF, "ovf_load");
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h7FFF, "ovf_add");
            if (i == 15) check_val("ovf_15_lit", Q, 20'h7FFF0);
        end
        check_val("ovf_16_lit", Q, 20'h87FEF);

        step(1'b0, 1'b1, 1'b1, 16'h1234, "rst_mid");
        check_val("rst_mid_lit", Q, 20'h00000);
        step(1'b1, 1'b1, 1'b0, 16'h0005, "rst_release");
        check_val("rst_release_lit", Q, 20'h00005);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 16'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/filter_accum.md
# filter_accum

Signed running-sum accumulator for the filter datapath. Each enabled clock either loads a new 16-bit signed sample or adds it to a 20-bit signed running total. It sits after the filter's tap/product stage and sums up to 16 full-scale terms without loss. The 4 guard bits cover that range; beyond it the sum wraps.

## Interface
Parameters:
- DATA_W, 16, input sample width (two's complement)
- ACC_W, 20, accumulator width (two's complement); must satisfy ACC_W > DATA_W

Ports:
- clk  input  1  rising-edge clock
- rstb  input  1  reset; one clock, reset is synchronous and active-low
- enable  input  1  when high, the register updates this cycle; when low, Q holds
- load  input  1  qualified by enable; high = restart the sum from D, low = accumulate D
- D  input  DATA_W  signed sample
- Q  output  ACC_W  registered signed running sum

## Operation
Register update at each rising clk edge, in priority order:
- rstb == 0 → Q <= 0. This overrides enable and load.
- enable == 0 → Q holds. load and D are ignored.
- enable == 1, load == 1 → Q <= sext(D), where sext sign-extends D to ACC_W bits.
- enable == 1, load == 0 → Q <= Q + sext(D).

Arithmetic rules:
- The add is modulo 2^ACC_W: two's-complement wrap.
- There is no saturation and no overflow flag.
- D is always signed. For example, 16'hFFFF = −1 and 16'hAA44 = −21948.
- Q is driven directly from the register, with no combinational path from any input to Q.
- load and enable are level-sensitive. Holding load high with enable high reloads the register every cycle.
- D may be X while enable == 0 or rstb == 0. Q must not be affected in those cycles.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on Q after edge N.
- Throughput is one sample per cycle, with no handshake or back-pressure.
- Reset value of Q is 0.
- Reset is synchronous: asserting rstb mid-accumulation clears Q at the next edge only.
- Releasing rstb with enable high: the first post-reset edge performs the load or add using Q = 0.
- Simultaneous load and reset: reset wins.
- Before the first edge with rstb low, Q is undefined.

## Structure
- Shared package filter_pkg holds:
  - DATA_W and ACC_W defaults
  - a sign-extend function sext(D) returning ACC_W bits
- A single always block on posedge clk implements the register.
- An adder/mux datapath feeds that register.
- An optional sub-module, filter_acc_datapath, holds the sext and add/select logic. It is combinational, and the wrapper keeps the register.
- Target size is 120–400 lines including parameter checks: an elaboration-time assertion that ACC_W > DATA_W.

## Test plan
- Reset, then directed sequence: hold rstb=0 for 10 cycles → Q=0x00000. Then rstb=1, enable=1, and apply one D per edge:
  - load=1, D=000A → Q=0x0000A
  - load=0, D=FFFF → Q=0x00009
  - D=0334 → Q=0x0033D
  - D=FFFF → Q=0x0033C
- Negative accumulation with wrap below zero: hold D=AA44 for 10 edges from Q=0x0033C → Q=0xFAD80 after the first edge, 0xCA9E4 after the tenth.
- Hold: enable=0 for 10 cycles with D toggling arbitrary values → Q stays constant.
- Repeated load, then count: enable=1, load=1, D=0000 for 10 edges → Q=0x00000. Then load=0, D=0001 for 10 edges → Q=0x0000A, incrementing by 1 per edge.
- Positive overflow wrap: load D=7FFF, then add 7FFF 16 times:
  - after 15 adds → Q=0x7FFF0
  - after 16 adds → Q=0x87FEF (wrapped negative)
- Reset mid-operation and priority: with enable=1 and load=1, drive rstb=0 for one edge → Q=0 on that edge. Deassert rstb while holding load=0 and D=0005 → Q=0x00005 at the next edge.
